// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the 1280x1024@60 pattern sequencer.
//   Default raster timing (108 MHz pixel clock), derived totals, counter width,
//   the pattern code enumeration and the pattern rotation helper.
package vga_pkg;

  localparam int H_PIXELS_DEF = 1280;
  localparam int H_FP_DEF     = 48;
  localparam int H_SYNC_DEF   = 112;
  localparam int H_BP_DEF     = 248;
  localparam int H_TOTAL_DEF  = H_PIXELS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;  // 1688

  localparam int V_LINES_DEF  = 1024;
  localparam int V_FP_DEF     = 1;
  localparam int V_SYNC_DEF   = 3;
  localparam int V_BP_DEF     = 38;
  localparam int V_TOTAL_DEF  = V_LINES_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;   // 1066

  localparam int CNT_W = 11;

  typedef enum logic [1:0] {
    PAT_SOLID   = 2'd0,
    PAT_STRIPES = 2'd1,
    PAT_BARS    = 2'd2,
    PAT_CHECK   = 2'd3
  } pattern_t;

  function automatic pattern_t next_pattern(input pattern_t p);
    case (p)
      PAT_SOLID:   return PAT_STRIPES;
      PAT_STRIPES: return PAT_BARS;
      PAT_BARS:    return PAT_CHECK;
      default:     return PAT_SOLID;
    endcase
  endfunction

endpackage

// File: rtl/vga_timing_1280x1024.sv
// vga_timing_1280x1024: raster counters and raw (unregistered) timing flags.
//   clk        in   pixel clock
//   clr        in   asynchronous active-high reset
//   hc, vc     out  horizontal / vertical counters
//   hsync_raw  out  horizontal sync derived from hc (active level SYNC_POL)
//   vsync_raw  out  vertical sync derived from vc (active level SYNC_POL)
//   vidon_raw  out  visible-region flag for the current (hc,vc)
//   frame_tick out  high on the last pixel of the frame
module vga_timing_1280x1024
  import vga_pkg::*;
#(
  parameter int H_PIXELS = H_PIXELS_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_LINES  = V_LINES_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  output logic [CNT_W-1:0] hc,
  output logic [CNT_W-1:0] vc,
  output logic             hsync_raw,
  output logic             vsync_raw,
  output logic             vidon_raw,
  output logic             frame_tick
);

  localparam int H_TOTAL = H_PIXELS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_LINES + V_FP + V_SYNC + V_BP;

  logic [CNT_W-1:0] hc_reg, hc_next;
  logic [CNT_W-1:0] vc_reg, vc_next;
  logic             h_end, v_end;

  assign h_end = (hc_reg == CNT_W'(H_TOTAL - 1));
  assign v_end = (vc_reg == CNT_W'(V_TOTAL - 1));

  always_comb begin
    hc_next = h_end ? '0 : hc_reg + CNT_W'(1);
    vc_next = vc_reg;
    if (h_end) begin
      vc_next = v_end ? '0 : vc_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      hc_reg <= '0;
      vc_reg <= '0;
    end else begin
      hc_reg <= hc_next;
      vc_reg <= vc_next;
    end
  end

  assign hc = hc_reg;
  assign vc = vc_reg;

  assign hsync_raw = ((hc_reg >= CNT_W'(H_PIXELS + H_FP)) &&
                      (hc_reg <  CNT_W'(H_PIXELS + H_FP + H_SYNC))) ? SYNC_POL : ~SYNC_POL;
  assign vsync_raw = ((vc_reg >= CNT_W'(V_LINES + V_FP)) &&
                      (vc_reg <  CNT_W'(V_LINES + V_FP + V_SYNC))) ? SYNC_POL : ~SYNC_POL;
  assign vidon_raw  = (hc_reg < CNT_W'(H_PIXELS)) && (vc_reg < CNT_W'(V_LINES));
  assign frame_tick = h_end && v_end;

endmodule

// File: rtl/vga_pattern_sequencer.sv
// vga_pattern_sequencer: raster timing plus frame-synchronous test pattern scheduling.
//   clk        in   pixel clock (108 MHz at default timing)
//   clr        in   asynchronous active-high reset
//   next_req   in   pulse: advance pattern at the next frame boundary
//   hold       in   1 = suspend auto-advance (requests still honoured)
//   next_ack   out  pulse on the boundary cycle that applies a requested advance
//   hc, vc     out  raw raster counters
//   hsync      out  registered horizontal sync, aligned with RGB
//   vsync      out  registered vertical sync, aligned with RGB
//   vidon      out  registered visible flag, aligned with RGB
//   frame_tick out  pulse on the last pixel of each frame
//   pattern    out  current pattern code
//   red/green/blue out registered 3/3/2 colour, zero outside the visible area
module vga_pattern_sequencer
  import vga_pkg::*;
#(
  parameter int H_PIXELS           = H_PIXELS_DEF,
  parameter int H_FP               = H_FP_DEF,
  parameter int H_SYNC             = H_SYNC_DEF,
  parameter int H_BP               = H_BP_DEF,
  parameter int V_LINES            = V_LINES_DEF,
  parameter int V_FP               = V_FP_DEF,
  parameter int V_SYNC             = V_SYNC_DEF,
  parameter int V_BP               = V_BP_DEF,
  parameter bit SYNC_POL           = 1'b1,
  parameter int FRAMES_PER_PATTERN = 120,
  parameter int STRIPE_LOG2        = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             next_req,
  input  logic             hold,
  output logic             next_ack,
  output logic [CNT_W-1:0] hc,
  output logic [CNT_W-1:0] vc,
  output logic             hsync,
  output logic             vsync,
  output logic             vidon,
  output logic             frame_tick,
  output logic [1:0]       pattern,
  output logic [2:0]       red,
  output logic [2:0]       green,
  output logic [1:0]       blue
);

  // Eight equal bars across the visible width (160 px at 1280).
  localparam int BAR_W = (H_PIXELS / 8 > 0) ? H_PIXELS / 8 : 1;
  localparam int FC_W  = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
  localparam logic [FC_W-1:0] FC_MAX = FC_W'(FRAMES_PER_PATTERN - 1);

  logic hsync_raw, vsync_raw, vidon_raw;

  vga_timing_1280x1024 #(
    .H_PIXELS (H_PIXELS),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_LINES  (V_LINES),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .SYNC_POL (SYNC_POL)
  ) u_timing (
    .clk        (clk),
    .clr        (clr),
    .hc         (hc),
    .vc         (vc),
    .hsync_raw  (hsync_raw),
    .vsync_raw  (vsync_raw),
    .vidon_raw  (vidon_raw),
    .frame_tick (frame_tick)
  );

  // ---------------- pattern FSM and request latch ----------------
  pattern_t         pattern_reg, pattern_next;
  logic [FC_W-1:0]  frame_cnt_reg, frame_cnt_next;
  logic             pending_reg, pending_next;
  logic             auto_due, req_seen;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pattern_reg   <= PAT_SOLID;
      frame_cnt_reg <= '0;
      pending_reg   <= 1'b0;
    end else begin
      pattern_reg   <= pattern_next;
      frame_cnt_reg <= frame_cnt_next;
      pending_reg   <= pending_next;
    end
  end

  always_comb begin
    // A request arriving on the boundary cycle itself is folded in directly.
    req_seen       = pending_reg | next_req;
    auto_due       = (frame_cnt_reg == FC_MAX) && !hold;
    pattern_next   = pattern_reg;
    frame_cnt_next = frame_cnt_reg;
    pending_next   = req_seen;
    next_ack       = 1'b0;
    if (frame_tick) begin
      if (auto_due || req_seen) begin
        pattern_next   = next_pattern(pattern_reg);
        frame_cnt_next = '0;
        pending_next   = 1'b0;
        next_ack       = req_seen;
      end else if (frame_cnt_reg != FC_MAX) begin
        // Saturates at the limit so that releasing hold advances at the next boundary.
        frame_cnt_next = frame_cnt_reg + FC_W'(1);
      end
    end
  end

  assign pattern = pattern_reg;

  // ---------------- colour generation ----------------
  logic [2:0]       red_next, green_next;
  logic [1:0]       blue_next;
  logic [CNT_W-1:0] bar_full;
  logic [2:0]       bar_idx;

  always_comb begin
    bar_full   = hc / CNT_W'(BAR_W);
    bar_idx    = bar_full[2:0];
    red_next   = 3'd0;
    green_next = 3'd0;
    blue_next  = 2'd0;
    if (vidon_raw) begin
      case (pattern_reg)
        PAT_SOLID: begin
          green_next = 3'd7;
        end
        PAT_STRIPES: begin
          if (vc[STRIPE_LOG2]) green_next = 3'd7;
          else                 red_next   = 3'd7;
        end
        PAT_BARS: begin
          red_next   = {3{bar_idx[2]}};
          green_next = {3{bar_idx[1]}};
          blue_next  = {2{bar_idx[0]}};
        end
        default: begin
          if (hc[6] ^ vc[6]) begin
            red_next   = 3'd7;
            green_next = 3'd7;
            blue_next  = 2'd3;
          end
        end
      endcase
    end
  end

  // Single output stage keeps sync/vidon aligned with the colour.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      red   <= 3'd0;
      green <= 3'd0;
      blue  <= 2'd0;
      hsync <= ~SYNC_POL;
      vsync <= ~SYNC_POL;
      vidon <= 1'b0;
    end else begin
      red   <= red_next;
      green <= green_next;
      blue  <= blue_next;
      hsync <= hsync_raw;
      vsync <= vsync_raw;
      vidon <= vidon_raw;
    end
  end

endmodule
